// File: rtl/line_rasterizer.sv
// Bresenham line walker: takes one line primitive per start strobe and emits
// one pixel per accepted beat, clipping points outside the visible raster.
module line_rasterizer #(
   parameter int unsigned XW    = 10,
   parameter int unsigned YW    = 9,
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   prim_sel,
   input  logic [2*(XW+YW)-1:0]   locations,
   input  logic [15:0]            color,
   input  logic                   pix_ready,
   output logic                   pix_valid,
   output logic [XW-1:0]          pix_x,
   output logic [YW-1:0]          pix_y,
   output logic [15:0]            pix_color,
   output logic                   busy,
   output logic                   line_done
);

   localparam int unsigned PW  = XW + YW;
   localparam int unsigned EW  = XW + 2;
   localparam int unsigned E2W = EW + 1;

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_e;

   state_e               state_q, state_d;
   logic [XW-1:0]        cx_q, cx_d, x1_q, x1_d, dx_q, dx_d, adx;
   logic [YW-1:0]        cy_q, cy_d, y1_q, y1_d, ady;
   logic signed [EW-1:0] dy_q, dy_d, err_q, err_d;
   logic signed [E2W-1:0] e2, dx_e2, dy_e2;
   logic                 sx_q, sx_d, sy_q, sy_d;
   logic [15:0]          color_q, color_d;
   logic                 pix_valid_q, pix_valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 start, advance, at_end;

   assign start   = (state_q == S_IDLE) && enable && !prim_sel;
   assign advance = (state_q == S_DRAW) && (!pix_valid_q || pix_ready);
   assign at_end  = (cx_q == x1_q) && (cy_q == y1_q);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SETUP;
         S_SETUP: state_d = S_DRAW;
         S_DRAW:  if (advance && at_end) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: latch, setup and Bresenham step
   always_comb begin
      cx_d    = cx_q;
      cy_d    = cy_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      err_d   = err_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      color_d = color_q;
      adx     = (x1_q >= cx_q) ? (x1_q - cx_q) : (cx_q - x1_q);
      ady     = (y1_q >= cy_q) ? (y1_q - cy_q) : (cy_q - y1_q);
      e2      = $signed({err_q, 1'b0});
      dx_e2   = $signed({{(E2W-XW){1'b0}}, dx_q});
      dy_e2   = $signed({dy_q[EW-1], dy_q});

      if (start) begin
         cx_d    = locations[2*PW-1 -: XW];
         cy_d    = locations[PW+YW-1 -: YW];
         x1_d    = locations[PW-1 -: XW];
         y1_d    = locations[YW-1:0];
         color_d = color;
      end

      // cx/cy already hold p0, so the deltas come straight from them
      if (state_q == S_SETUP) begin
         dx_d  = adx;
         dy_d  = -$signed({{(EW-YW){1'b0}}, ady});
         err_d = $signed({{(EW-XW){1'b0}}, adx}) - $signed({{(EW-YW){1'b0}}, ady});
         sx_d  = !(cx_q < x1_q);
         sy_d  = !(cy_q < y1_q);
      end

      // Both axis updates compare against the pre-update e2
      if (advance && !at_end) begin
         if (e2 >= dy_e2) begin
            err_d = err_d + dy_q;
            cx_d  = sx_q ? (cx_q - XW'(1)) : (cx_q + XW'(1));
         end
         if (e2 <= dx_e2) begin
            err_d = err_d + $signed({{(EW-XW){1'b0}}, dx_q});
            cy_d  = sy_q ? (cy_q - YW'(1)) : (cy_q + YW'(1));
         end
      end
   end

   // Output next values, derived from the upcoming state and point
   always_comb begin
      pix_valid_d = (state_d == S_DRAW) && (32'(cx_d) < H_RES) && (32'(cy_d) < V_RES);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cx_q        <= '0;
         cy_q        <= '0;
         x1_q        <= '0;
         y1_q        <= '0;
         dx_q        <= '0;
         dy_q        <= '0;
         err_q       <= '0;
         sx_q        <= 1'b0;
         sy_q        <= 1'b0;
         color_q     <= '0;
         pix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         x1_q        <= x1_d;
         y1_q        <= y1_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         err_q       <= err_d;
         sx_q        <= sx_d;
         sy_q        <= sy_d;
         color_q     <= color_d;
         pix_valid_q <= pix_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pix_valid = pix_valid_q;
   assign pix_x     = cx_q;
   assign pix_y     = cy_q;
   assign pix_color = color_q;
   assign busy      = busy_q;
   assign line_done = done_q;

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: vector table of lines with expected
// pixel lists, a pixel scoreboard, plus hand sequences for stall/reset/control.
module tb_line_rasterizer;

   logic        clk = 1'b0;
   logic        reset, enable, prim_sel, pix_ready;
   logic [37:0] locations;
   logic [15:0] color;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_color;
   logic        busy, line_done;

   int checks   = 0;
   int failures = 0;
   int pix_seen = 0;

   typedef struct {
      logic [9:0]  x;
      logic [8:0]  y;
      logic [15:0] c;
   } px_t;

   typedef struct {
      logic [9:0]  x0;
      logic [8:0]  y0;
      logic [9:0]  x1;
      logic [8:0]  y1;
      logic [15:0] col;
      int          npts;
   } vec_t;

   typedef struct {
      int         id;
      logic [9:0] x;
      logic [8:0] y;
   } px_rec_t;

   px_t     exp_q[$];
   vec_t    vecs[$];
   px_rec_t pxs[$];

   line_rasterizer dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .prim_sel  (prim_sel),
      .locations (locations),
      .color     (color),
      .pix_ready (pix_ready),
      .pix_valid (pix_valid),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_color (pix_color),
      .busy      (busy),
      .line_done (line_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted beat must match the next expected pixel
   always @(negedge clk) begin
      px_t e;
      if (pix_valid && pix_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pixel actual=(%0d,%0d) required=none", pix_x, pix_y);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("pixel%0d(%0d,%0d)", pix_seen, e.x, e.y),
                {pix_x, pix_y, pix_color}, {e.x, e.y, e.c});
         end
         pix_seen++;
      end
   end

   task automatic add_v(input int x0, input int y0, input int x1, input int y1,
                        input logic [15:0] c, input int n);
      vecs.push_back('{10'(x0), 9'(y0), 10'(x1), 9'(y1), c, n});
   endtask

   task automatic add_p(input int x, input int y);
      pxs.push_back('{vecs.size() - 1, 10'(x), 9'(y)});
   endtask

   task automatic push_px(input int x, input int y, input logic [15:0] c);
      exp_q.push_back('{10'(x), 9'(y), c});
   endtask

   // Returns just after the edge that samples enable
   task automatic start_line(input logic [9:0] x0, input logic [8:0] y0,
                             input logic [9:0] x1, input logic [8:0] y1,
                             input logic [15:0] c);
      @(posedge clk);
      #1;
      locations = {x0, y0, x1, y1};
      color     = c;
      enable    = 1'b1;
      prim_sel  = 1'b0;
      @(posedge clk);
      #1;
      enable    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_cyc, input bit chk_lat);
      int cyc  = 0;
      bit seen = 1'b0;
      while (cyc < 300 && !seen) begin
         @(negedge clk);
         cyc++;
         if (chk_lat && cyc == 1) chk({name, "_setup_busy_valid"}, {busy, pix_valid}, 2'b10);
         if (chk_lat && cyc == 2) chk({name, "_first_valid"}, pix_valid, 1'b1);
         if (line_done) seen = 1'b1;
      end
      chk({name, "_done_seen"}, seen, 1'b1);
      chk({name, "_done_cycle"}, cyc, exp_cyc);
      @(negedge clk);
      chk({name, "_idle_after"}, {busy, line_done}, 2'b00);
      chk({name, "_all_pixels"}, exp_q.size(), 0);
   endtask

   task automatic run_vec(input int i);
      foreach (pxs[k])
         if (pxs[k].id == i) push_px(pxs[k].x, pxs[k].y, vecs[i].col);
      start_line(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].col);
      wait_done($sformatf("vec%0d", i), vecs[i].npts + 2, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      bit any;

      add_v(0, 0, 3, 0, 16'h07E0, 4);
      add_p(0, 0); add_p(1, 0); add_p(2, 0); add_p(3, 0);
      add_v(5, 5, 2, 2, 16'hF800, 4);
      add_p(5, 5); add_p(4, 4); add_p(3, 3); add_p(2, 2);
      add_v(0, 0, 1, 3, 16'h001F, 4);
      add_p(0, 0); add_p(0, 1); add_p(1, 2); add_p(1, 3);
      add_v(639, 479, 639, 479, 16'hFFFF, 1);
      add_p(639, 479);
      add_v(638, 0, 641, 0, 16'h0A5A, 4);
      add_p(638, 0); add_p(639, 0);
      add_v(0, 0, 7, 3, 16'h1357, 8);
      add_p(0, 0); add_p(1, 0); add_p(2, 1); add_p(3, 1);
      add_p(4, 2); add_p(5, 2); add_p(6, 3); add_p(7, 3);
      add_v(3, 5, 3, 1, 16'h2468, 5);
      add_p(3, 5); add_p(3, 4); add_p(3, 3); add_p(3, 2); add_p(3, 1);

      reset     = 1'b1;
      enable    = 1'b0;
      prim_sel  = 1'b0;
      pix_ready = 1'b1;
      locations = '0;
      color     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {pix_valid, pix_x, pix_y, pix_color, busy, line_done}, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (vecs[i]) run_vec(i);

      // Backpressure: second pixel stalled three cycles
      push_px(10, 7, 16'hBEEF); push_px(11, 7, 16'hBEEF); push_px(12, 7, 16'hBEEF);
      start_line(10'd10, 9'd7, 10'd12, 9'd7, 16'hBEEF);
      @(posedge clk);
      @(posedge clk);
      #1;
      pix_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_hold", s), {pix_valid, pix_x, pix_y, pix_color},
             {1'b1, 10'd11, 9'd7, 16'hBEEF});
      end
      @(posedge clk);
      #1;
      pix_ready = 1'b1;
      wait_done("stall", 3, 1'b0);

      // Reset while the second pixel is presented
      push_px(0, 0, 16'h0F0F); push_px(1, 0, 16'h0F0F);
      start_line(10'd0, 9'd0, 10'd9, 9'd0, 16'h0F0F);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_idle", {pix_valid, busy, line_done}, 3'b000);
      any = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (line_done || busy || pix_valid) any = 1'b1;
      end
      chk("midreset_quiet", any, 1'b0);
      chk("midreset_scoreboard", exp_q.size(), 0);
      run_vec(0);

      // Arc primitive is ignored
      @(posedge clk);
      #1;
      locations = {10'd1, 9'd1, 10'd4, 9'd1};
      enable    = 1'b1;
      prim_sel  = 1'b1;
      @(posedge clk);
      #1;
      enable    = 1'b0;
      prim_sel  = 1'b0;
      any = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (busy || pix_valid || line_done) any = 1'b1;
      end
      chk("arc_ignored", any, 1'b0);

      // Reset wins over a simultaneous enable
      @(posedge clk);
      #1;
      locations = {10'd1, 9'd1, 10'd4, 9'd1};
      reset     = 1'b1;
      enable    = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      enable    = 1'b0;
      any = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busy || pix_valid || line_done) any = 1'b1;
      end
      chk("reset_beats_enable", any, 1'b0);

      run_vec(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/line_rasterizer.md
Name: line_rasterizer

Overview:
Downstream consumer of the shape detection stage. It accepts one line primitive per handshake: two packed 19-bit endpoints plus a 16-bit colour. It walks the line with integer Bresenham stepping and emits one pixel per accepted beat toward the frame-buffer writer. When the last pixel is accepted it pulses line_done back to the shape detector, which then advances to the next triangle edge or to the next opcode.

Parameters:
XW, 10, x coordinate width; location bits [18:9]
YW, 9, y coordinate width; location bits [8:0]
H_RES, 640, pixels with x >= H_RES are suppressed
V_RES, 480, pixels with y >= V_RES are suppressed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  start strobe from shape detector, sampled in IDLE only
prim_sel  in  1  0 = line primitive (accepted); 1 = arc (ignored by this block)
locations  in  38  {p0[18:0], p1[18:0]}; each point packed as {x[9:0], y[8:0]}
color  in  16  RGB565 pixel colour
pix_ready  in  1  frame-buffer writer can accept a pixel this cycle
pix_valid  out  1  pix_x/pix_y/pix_color hold a pixel
pix_x  out  10  pixel x
pix_y  out  9  pixel y
pix_color  out  16  latched colour
busy  out  1  high in any state other than IDLE
line_done  out  1  single-cycle pulse after the last pixel is accepted

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; internal registers 0.
- State machine: IDLE -> SETUP -> DRAW -> DONE -> IDLE.
- IDLE:
  - If enable && !prim_sel: latch x0, y0, x1, y1 and color; go to SETUP.
  - If enable && prim_sel: no action.
- SETUP (1 cycle):
  - dx = |x1 - x0| (10-bit unsigned); dy = -|y1 - y0|.
  - sx = +1 if x0 < x1, else -1; sy = +1 if y0 < y1, else -1.
  - err = dx + dy, held in a 12-bit signed register.
  - Current point (cx, cy) = (x0, y0).
- DRAW:
  - Present (cx, cy, color).
  - pix_valid = 1 only when cx < H_RES && cy < V_RES.
  - An off-screen point is consumed internally in one cycle with pix_valid = 0.
  - Advance on accept: (pix_valid && pix_ready) or an off-screen point.
  - On advance, if (cx, cy) == (x1, y1): go to DONE.
  - Otherwise, with e2 = 2*err (13-bit signed):
    - if e2 >= dy: err += dy, cx += sx;
    - if e2 <= dx: err += dx, cy += sy.
    - Both updates may apply in the same cycle, using the pre-update e2.
  - While pix_valid && !pix_ready: x, y, color and err are held stable. pix_valid never drops without an accept.
- DONE: line_done = 1 for exactly one cycle; return to IDLE.
- Latency: enable seen at edge N gives the first pix_valid at edge N+2. line_done is asserted the cycle after the final accept.
- Pixel count = max(dx, |dy|) + 1.
- Degenerate line p0 == p1: exactly one pixel, then line_done.
- enable while busy is ignored; no queueing. The upstream block must wait for line_done.
- reset mid-line: IDLE on the next edge; pix_valid drops; no line_done; the partial line is abandoned.
- Simultaneous reset and enable: reset wins.
- Coordinates never wrap. The end check stops stepping at p1, so cx/cy stay within [min, max] of the endpoints.

Test Plan:
- Horizontal: p0 = (0,0), p1 = (3,0), pix_ready = 1 -> pixels (0,0), (1,0), (2,0), (3,0) on consecutive cycles starting 2 cycles after enable; line_done one cycle after (3,0); busy low the cycle after that.
- Reverse diagonal: p0 = (5,5), p1 = (2,2) -> pixels (5,5), (4,4), (3,3), (2,2); all pixels carry color 16'hF800.
- Steep: p0 = (0,0), p1 = (1,3) -> pixels exactly (0,0), (0,1), (1,2), (1,3); 4 beats.
- Backpressure: horizontal (10,7) -> (12,7) with pix_ready low for 3 cycles on the 2nd pixel -> (11,7) held stable 4 cycles; 3 pixels total; no duplicates or skips.
- Point and clipping: p0 = p1 = (639,479) -> one pixel then line_done. p0 = (638,0), p1 = (641,0) -> only x = 638 and 639 emitted; line_done still pulses.
- Control: enable with prim_sel = 1 -> busy stays 0, no pixels. Reset asserted on the 2nd pixel of (0,0) -> (9,0) -> pix_valid 0 next cycle, no line_done. A fresh enable afterward draws correctly.
